// File: rtl/sc_ulpi_pkg.sv
// Shared ULPI constants, register-byte builders and the register-access engine state type.
// Used by the ULPI register access engine.
package sc_ulpi_pkg;

    localparam logic [1:0] TXCMD_REGW = 2'b10;
    localparam logic [1:0] TXCMD_REGR = 2'b11;

    localparam logic [5:0] ADDR_FUNC_CTRL = 6'h04;
    localparam logic [5:0] ADDR_OTG_CTRL  = 6'h0A;

    localparam int FC_SUSPENDM_BIT = 6;
    localparam int FC_RESET_BIT    = 5;
    localparam int OTG_DMPD_BIT    = 2;
    localparam int OTG_DPPD_BIT    = 1;

    typedef enum logic [3:0] {
        URA_IDLE  = 4'd0,
        URA_TXCMD = 4'd1,
        URA_WDAT  = 4'd2,
        URA_STP   = 4'd3,
        URA_RTA   = 4'd4,
        URA_RDAT  = 4'd5,
        URA_RTB   = 4'd6,
        URA_DONE  = 4'd7,
        URA_ABT   = 4'd8
    } ura_state_t;

    // SuspendM is forced high and Reset low; the port state fills the low five bits.
    function automatic logic [7:0] func_ctrl_byte(input logic [4:0] st);
        logic [7:0] b;
        b                  = {3'b000, st};
        b[FC_SUSPENDM_BIT] = 1'b1;
        b[FC_RESET_BIT]    = 1'b0;
        return b;
    endfunction

    function automatic logic [7:0] otg_ctrl_byte(input logic host);
        logic [7:0] b;
        b               = 8'h00;
        b[OTG_DMPD_BIT] = host;
        b[OTG_DPPD_BIT] = host;
        return b;
    endfunction

endpackage

// File: rtl/sc_scbc_ura_arb.sv
// Two-requester fixed-priority arbiter (UPSI over ULLA) for the ULPI register engine.
// Latches the owner at grant and steers the one-cycle completion pulse back to it.
module sc_scbc_ura_arb (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic upsi_req_i,
    input  logic ulla_req_i,
    input  logic en_i,
    input  logic done_i,
    output logic grant_o,
    output logic sel_ulla_o,
    output logic upsi_ack_o,
    output logic ulla_ack_o
);

    logic owner_ulla_q;
    logic owner_ulla_d;
    logic upsi_ack_q;
    logic ulla_ack_q;

    // Grant decision and owner next-state
    always_comb begin
        grant_o    = en_i & (upsi_req_i | ulla_req_i);
        sel_ulla_o = ~upsi_req_i & ulla_req_i;
        if (grant_o) begin
            owner_ulla_d = sel_ulla_o;
        end else begin
            owner_ulla_d = owner_ulla_q;
        end
    end

    // Owner latch and routed ack registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_ulla_q <= 1'b0;
            upsi_ack_q   <= 1'b0;
            ulla_ack_q   <= 1'b0;
        end else begin
            owner_ulla_q <= owner_ulla_d;
            upsi_ack_q   <= done_i & ~owner_ulla_q;
            ulla_ack_q   <= done_i & owner_ulla_q;
        end
    end

    assign upsi_ack_o = upsi_ack_q;
    assign ulla_ack_o = ulla_ack_q;

endmodule

// File: rtl/sc_scbc_ura.sv
// ULPI register access engine: runs UPSI/ULLA requests as immediate-address register
// writes/reads on the ULPI bus. All bus outputs are registered decodes of the next state.
module sc_scbc_ura
    import sc_ulpi_pkg::*;
#(
    parameter int NXT_TIMEOUT = 1024
) (
    input  logic       ULPICLK,
    input  logic       ULPIRSTB,
    input  logic       UPSI_REQ,
    output logic       UPSI_ACK,
    input  logic       UPSI_TYPE,
    input  logic [4:0] UPSI_STATE,
    input  logic       UPSI_CFG,
    input  logic       ULLA_REQ,
    output logic       ULLA_ACK,
    input  logic       ULLA_WR0RD1,
    input  logic [7:0] ULLA_ADDR,
    input  logic [7:0] ULLA_WRDATA,
    output logic [7:0] URC_DATA,
    input  logic       ULPI_DIR,
    input  logic       ULPI_NXT,
    output logic       ULPI_STP,
    input  logic [7:0] ULPI_DATA_I,
    output logic [7:0] ULPI_DATA_O,
    input  logic       ULPI_TXBUSY,
    output logic       URA_BUSY,
    output logic       URA_TOUT
);

    localparam int CW = $clog2(NXT_TIMEOUT);
    // Last wait cycle: TXCMD is entered one cycle after grant, so the ack lands at NXT_TIMEOUT+2.
    localparam logic [CW-1:0] TMO_LAST = CW'(NXT_TIMEOUT - 2);

    ura_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rd_q, rd_d;
    logic [5:0]    addr_q, addr_d;
    logic [7:0]    wdat_q, wdat_d;
    logic          tfl_q, tfl_d;
    logic          hold_q;
    logic [7:0]    data_q, data_d;
    logic          stp_q, stp_d;
    logic          busy_q, busy_d;
    logic          tout_q, tout_d;
    logic          done_d;
    logic [7:0]    urc_q;
    logic          arb_en_s, grant_s, sel_ulla_s;
    logic          unused_addr_s;

    assign unused_addr_s = ^ULLA_ADDR[7:6];
    assign arb_en_s = (state_q == URA_IDLE) & ~ULPI_DIR & ~ULPI_TXBUSY & ~hold_q;

    sc_scbc_ura_arb u_arb (
        .clk_i      (ULPICLK),
        .rst_ni     (ULPIRSTB),
        .upsi_req_i (UPSI_REQ),
        .ulla_req_i (ULLA_REQ),
        .en_i       (arb_en_s),
        .done_i     (done_d),
        .grant_o    (grant_s),
        .sel_ulla_o (sel_ulla_s),
        .upsi_ack_o (UPSI_ACK),
        .ulla_ack_o (ULLA_ACK)
    );

    // Next-state, transaction latch and NXT wait counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        tfl_d   = tfl_q;
        case (state_q)
            URA_IDLE: begin
                if (grant_s) begin
                    state_d = URA_TXCMD;
                    cnt_d   = '0;
                    tfl_d   = 1'b0;
                    if (sel_ulla_s) begin
                        rd_d   = ULLA_WR0RD1;
                        addr_d = ULLA_ADDR[5:0];
                        wdat_d = ULLA_WRDATA;
                    end else if (UPSI_TYPE == 1'b0) begin
                        rd_d   = 1'b0;
                        addr_d = ADDR_FUNC_CTRL;
                        wdat_d = func_ctrl_byte(UPSI_STATE);
                    end else begin
                        rd_d   = 1'b0;
                        addr_d = ADDR_OTG_CTRL;
                        wdat_d = otg_ctrl_byte(UPSI_CFG);
                    end
                end else begin
                    state_d = URA_IDLE;
                end
            end
            URA_TXCMD, URA_WDAT: begin
                if (ULPI_DIR) begin
                    state_d = URA_ABT;
                end else if (ULPI_NXT) begin
                    cnt_d = '0;
                    if (state_q == URA_WDAT) begin
                        state_d = URA_STP;
                    end else if (rd_q) begin
                        state_d = URA_RTA;
                    end else begin
                        state_d = URA_WDAT;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    state_d = URA_STP;
                    tfl_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            URA_STP:  state_d = URA_DONE;
            URA_RTA:  state_d = URA_RDAT;
            URA_RDAT: state_d = URA_RTB;
            URA_RTB: begin
                if (!ULPI_DIR) begin
                    state_d = URA_DONE;
                end else begin
                    state_d = URA_RTB;
                end
            end
            URA_ABT: begin
                if (!ULPI_DIR) begin
                    state_d = URA_TXCMD;
                    cnt_d   = '0;
                end else begin
                    state_d = URA_ABT;
                end
            end
            URA_DONE: state_d = URA_IDLE;
            default:  state_d = URA_IDLE;
        endcase
    end

    // Bus output decode of the next state, so registered outputs track the state
    always_comb begin
        data_d = 8'h00;
        stp_d  = 1'b0;
        busy_d = 1'b0;
        tout_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            URA_TXCMD: begin
                data_d = {(rd_d ? TXCMD_REGR : TXCMD_REGW), addr_d};
                busy_d = 1'b1;
            end
            URA_WDAT: begin
                data_d = wdat_d;
                busy_d = 1'b1;
            end
            URA_STP: begin
                stp_d  = 1'b1;
                busy_d = 1'b1;
            end
            URA_RTA, URA_RDAT, URA_RTB, URA_ABT: busy_d = 1'b1;
            URA_DONE: begin
                done_d = 1'b1;
                tout_d = tfl_d;
            end
            default: data_d = 8'h00;
        endcase
    end

    // State, transaction and output registers
    always_ff @(posedge ULPICLK or negedge ULPIRSTB) begin
        if (!ULPIRSTB) begin
            state_q <= URA_IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            addr_q  <= 6'h00;
            wdat_q  <= 8'h00;
            tfl_q   <= 1'b0;
            hold_q  <= 1'b0;
            data_q  <= 8'h00;
            stp_q   <= 1'b0;
            busy_q  <= 1'b0;
            tout_q  <= 1'b0;
            urc_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            tfl_q   <= tfl_d;
            hold_q  <= (state_q == URA_DONE);
            data_q  <= data_d;
            stp_q   <= stp_d;
            busy_q  <= busy_d;
            tout_q  <= tout_d;
            if (state_q == URA_RDAT) begin
                urc_q <= ULPI_DATA_I;
            end else begin
                urc_q <= urc_q;
            end
        end
    end

    assign ULPI_DATA_O = data_q;
    assign ULPI_STP    = stp_q;
    assign URA_BUSY    = busy_q;
    assign URA_TOUT    = tout_q;
    assign URC_DATA    = urc_q;

endmodule

// File: tb/tb_sc_scbc_ura.sv
// Self-checking bench for sc_scbc_ura: vector table plus hand-written corner sequences,
// with a scoreboard of expected acks checked by a monitor.
module tb_sc_scbc_ura;

    localparam int TMO = 1024;

    logic       clk = 1'b0;
    logic       ULPIRSTB, UPSI_REQ, UPSI_ACK, UPSI_TYPE, UPSI_CFG;
    logic [4:0] UPSI_STATE;
    logic       ULLA_REQ, ULLA_ACK, ULLA_WR0RD1;
    logic [7:0] ULLA_ADDR, ULLA_WRDATA, URC_DATA;
    logic       ULPI_DIR, ULPI_NXT, ULPI_STP, ULPI_TXBUSY, URA_BUSY, URA_TOUT;
    logic [7:0] ULPI_DATA_I, ULPI_DATA_O;

    typedef struct {
        logic       upsi;
        logic       typ;
        logic [4:0] st;
        logic       cfg;
        logic       rd;
        logic [7:0] addr;
        logic [7:0] wd;
        logic [7:0] phy;
        logic [7:0] exp_cmd;
        logic [7:0] exp_wd;
        logic [7:0] exp_urc;
    } vec_t;

    typedef struct {
        logic       is_ulla;
        logic       tout;
        logic [7:0] urc;
    } sb_t;

    vec_t vecs [7];
    sb_t  sb_q [$];
    int   checks   = 0;
    int   failures = 0;

    sc_scbc_ura #(.NXT_TIMEOUT(TMO)) dut (
        .ULPICLK     (clk),
        .ULPIRSTB    (ULPIRSTB),
        .UPSI_REQ    (UPSI_REQ),
        .UPSI_ACK    (UPSI_ACK),
        .UPSI_TYPE   (UPSI_TYPE),
        .UPSI_STATE  (UPSI_STATE),
        .UPSI_CFG    (UPSI_CFG),
        .ULLA_REQ    (ULLA_REQ),
        .ULLA_ACK    (ULLA_ACK),
        .ULLA_WR0RD1 (ULLA_WR0RD1),
        .ULLA_ADDR   (ULLA_ADDR),
        .ULLA_WRDATA (ULLA_WRDATA),
        .URC_DATA    (URC_DATA),
        .ULPI_DIR    (ULPI_DIR),
        .ULPI_NXT    (ULPI_NXT),
        .ULPI_STP    (ULPI_STP),
        .ULPI_DATA_I (ULPI_DATA_I),
        .ULPI_DATA_O (ULPI_DATA_O),
        .ULPI_TXBUSY (ULPI_TXBUSY),
        .URA_BUSY    (URA_BUSY),
        .URA_TOUT    (URA_TOUT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%02h expected=0x%02h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every ack must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (ULPIRSTB && (UPSI_ACK || ULLA_ACK)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_ack", {6'b0, UPSI_ACK, ULLA_ACK}, 8'h00);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("ack_src", {6'b0, UPSI_ACK, ULLA_ACK}, e.is_ulla ? 8'h01 : 8'h02);
                chk("ack_urc", URC_DATA, e.urc);
                chk("ack_tout", {7'b0, URA_TOUT}, {7'b0, e.tout});
            end
        end
    end

    task automatic wait_busy();
        int k;
        k = 0;
        @(negedge clk);
        while (!URA_BUSY && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("busy_wait", {7'b0, URA_BUSY}, 8'h01);
    endtask

    task automatic ack_tail();
        @(negedge clk);
        chk("ack_pulse", {6'b0, UPSI_ACK, ULLA_ACK}, 8'h00);
        @(negedge clk);
        chk("post_ack_idle", {7'b0, URA_BUSY}, 8'h00);
    endtask

    task automatic wait_ack();
        int k;
        k = 0;
        @(negedge clk);
        while (!(UPSI_ACK || ULLA_ACK) && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("ack_seen", {7'b0, UPSI_ACK | ULLA_ACK}, 8'h01);
        ack_tail();
    endtask

    task automatic do_write(input logic [7:0] cmd, input logic [7:0] wd);
        chk("txcmd", ULPI_DATA_O, cmd);
        ULPI_NXT = 1'b1;
        @(negedge clk);
        chk("wdat", ULPI_DATA_O, wd);
        @(negedge clk);
        ULPI_NXT = 1'b0;
        chk("stp", {7'b0, ULPI_STP}, 8'h01);
        chk("stp_data", ULPI_DATA_O, 8'h00);
    endtask

    task automatic do_read(input logic [7:0] cmd, input logic [7:0] phy);
        chk("txcmd_rd", ULPI_DATA_O, cmd);
        ULPI_NXT = 1'b1;
        @(negedge clk);
        ULPI_NXT = 1'b0;
        ULPI_DIR = 1'b1;
        @(negedge clk);
        ULPI_DATA_I = phy;
        @(negedge clk);
        ULPI_DIR    = 1'b0;
        ULPI_DATA_I = 8'h00;
        chk("urc_rtb", URC_DATA, phy);
    endtask

    task automatic drive_vec(input vec_t v);
        UPSI_REQ    = v.upsi;
        UPSI_TYPE   = v.typ;
        UPSI_STATE  = v.st;
        UPSI_CFG    = v.cfg;
        ULLA_REQ    = ~v.upsi;
        ULLA_WR0RD1 = v.rd;
        ULLA_ADDR   = v.addr;
        ULLA_WRDATA = v.wd;
    endtask

    task automatic run_vec(input vec_t v);
        drive_vec(v);
        sb_q.push_back('{~v.upsi, 1'b0, v.exp_urc});
        wait_busy();
        if (v.rd) begin
            do_read(v.exp_cmd, v.phy);
        end else begin
            do_write(v.exp_cmd, v.exp_wd);
        end
        wait_ack();
        UPSI_REQ = 1'b0;
        ULLA_REQ = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic early;
        //         upsi  typ   st        cfg   rd    addr   wd     phy    cmd    wd     urc
        vecs[0] = '{1'b1, 1'b0, 5'b01001, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h84, 8'h49, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 5'b00000, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h8A, 8'h06, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 5'b11111, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h8A, 8'h00, 8'h00};
        vecs[3] = '{1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 8'hC5, 8'hA3, 8'h00, 8'h85, 8'hA3, 8'h00};
        vecs[4] = '{1'b0, 1'b0, 5'b00000, 1'b0, 1'b1, 8'h16, 8'h00, 8'h5A, 8'hD6, 8'h00, 8'h5A};
        vecs[5] = '{1'b0, 1'b0, 5'b00000, 1'b0, 1'b1, 8'h81, 8'h00, 8'hF0, 8'hC1, 8'h00, 8'hF0};
        vecs[6] = '{1'b1, 1'b0, 5'b10110, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h84, 8'h56, 8'hF0};

        ULPIRSTB = 1'b0; UPSI_REQ = 1'b0; UPSI_TYPE = 1'b0; UPSI_STATE = 5'b00000;
        UPSI_CFG = 1'b0; ULLA_REQ = 1'b0; ULLA_WR0RD1 = 1'b0; ULLA_ADDR = 8'h00;
        ULLA_WRDATA = 8'h00; ULPI_DIR = 1'b0; ULPI_NXT = 1'b0; ULPI_DATA_I = 8'h00;
        ULPI_TXBUSY = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data_o", ULPI_DATA_O, 8'h00);
        chk("rst_urc", URC_DATA, 8'h00);
        chk("rst_ctl", {3'b0, ULPI_STP, URA_BUSY, URA_TOUT, UPSI_ACK, ULLA_ACK}, 8'h00);
        ULPIRSTB = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // Simultaneous requests: UPSI first, ULLA after the mandatory idle cycle
        UPSI_REQ = 1'b1; UPSI_TYPE = 1'b0; UPSI_STATE = 5'b00000;
        ULLA_REQ = 1'b1; ULLA_WR0RD1 = 1'b0; ULLA_ADDR = 8'h07; ULLA_WRDATA = 8'h11;
        sb_q.push_back('{1'b0, 1'b0, 8'hF0});
        sb_q.push_back('{1'b1, 1'b0, 8'hF0});
        wait_busy();
        do_write(8'h84, 8'h40);
        wait_ack();
        UPSI_REQ = 1'b0;
        wait_busy();
        do_write(8'h87, 8'h11);
        wait_ack();
        ULLA_REQ = 1'b0;
        @(negedge clk);

        // PHY takes the bus during TXCMD before NXT
        UPSI_REQ = 1'b1; UPSI_TYPE = 1'b0; UPSI_STATE = 5'b01001;
        sb_q.push_back('{1'b0, 1'b0, 8'hF0});
        wait_busy();
        chk("abt_txcmd", ULPI_DATA_O, 8'h84);
        ULPI_DIR = 1'b1;
        @(negedge clk);
        chk("abt_data", ULPI_DATA_O, 8'h00);
        chk("abt_ctl", {6'b0, ULPI_STP, URA_BUSY}, 8'h01);
        @(negedge clk);
        ULPI_DIR = 1'b0;
        @(negedge clk);
        do_write(8'h84, 8'h49);
        wait_ack();
        UPSI_REQ = 1'b0;
        repeat (2) @(negedge clk);

        // NXT never comes: timeout ack at cycle TMO+2 counting the grant cycle as 1
        ULLA_REQ = 1'b1; ULLA_WR0RD1 = 1'b1; ULLA_ADDR = 8'h16;
        sb_q.push_back('{1'b1, 1'b1, 8'hF0});
        early = 1'b0;
        for (int c = 2; c <= TMO + 2; c++) begin
            @(negedge clk);
            if (c < TMO + 2 && (ULLA_ACK || URA_TOUT)) early = 1'b1;
            if (c == 2) chk("tout_txcmd", ULPI_DATA_O, 8'hD6);
            if (c == TMO + 1) chk("tout_stp", {7'b0, ULPI_STP}, 8'h01);
            if (c == TMO + 2) chk("tout_ack", {6'b0, ULLA_ACK, URA_TOUT}, 8'h03);
        end
        chk("tout_early", {7'b0, early}, 8'h00);
        ack_tail();
        ULLA_REQ = 1'b0;
        @(negedge clk);

        // Reset asserted in WDAT: outputs clear at once, no ack
        UPSI_REQ = 1'b1; UPSI_TYPE = 1'b1; UPSI_CFG = 1'b1;
        wait_busy();
        chk("rst_txcmd", ULPI_DATA_O, 8'h8A);
        ULPI_NXT = 1'b1;
        @(negedge clk);
        chk("rst_wdat", ULPI_DATA_O, 8'h06);
        ULPI_NXT = 1'b0;
        #1 ULPIRSTB = 1'b0;
        #1;
        chk("mid_rst_data", ULPI_DATA_O, 8'h00);
        chk("mid_rst_urc", URC_DATA, 8'h00);
        chk("mid_rst_ctl", {3'b0, ULPI_STP, URA_BUSY, URA_TOUT, UPSI_ACK, ULLA_ACK}, 8'h00);
        UPSI_REQ = 1'b0;
        repeat (2) @(negedge clk);
        ULPIRSTB = 1'b1;
        repeat (2) @(negedge clk);
        run_vec(vecs[0]);

        repeat (3) @(negedge clk);
        chk("sb_empty", 8'(sb_q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
